onchip_mem_arbiter: RTL

- Two-requester round-robin Avalon-MM arbiter in front of the single-port 32K x 32 on-chip RAM (1-cycle read latency, unregistered q).
- Requester 0 is the Nios II data master; requester 1 is the VIP frame-statistics writer.
- Sits between the two masters and the RAM slave.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken, and steers read data back to the requester that issued the read.

---
 rtl/onchip_mem_arb_pkg.sv | 21 ++
 rtl/onchip_mem_arbiter_rr_arb2.sv | 41 ++++
 rtl/onchip_mem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : onchip_mem_arb_pkg
// Shared defaults, FSM states and port indices for the on-chip RAM arbiter.
// Rev    : 1.0
// ============================================================================
package onchip_mem_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Two-input round-robin grant; the port that did not win last takes a tie.
// Rev    : 1.0
// ============================================================================
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (last_q == PORT_M1) ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (advance_i && (|gnt_o)) begin
      last_d = gnt_o[PORT_M1];
    end
  end

  // Reset to M1 so that M0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : onchip_mem_arbiter
// Round-robin Avalon-MM arbiter for a 1-cycle-latency single-port RAM.
// Optional clear engine: define ONCHIP_MEM_ARB_CLEAR_EN.
// Rev    : 1.0
// ============================================================================
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              clear_req,
  output logic              clear_busy
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              clearing;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_read;
  logic              sel_write;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              rowner_q;
  logic              rowner_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [ADDR_W-1:0] clr_addr;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .req_i     (req & {2{arb_en}}),
    .advance_i (arb_en),
    .gnt_o     (gnt)
  );

  assign any_gnt        = |gnt;
  assign m0_waitrequest = req[PORT_M0] & ~gnt[PORT_M0];
  assign m1_waitrequest = req[PORT_M1] & ~gnt[PORT_M1];

  always_comb begin
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_read  = m0_read;
    sel_write = m0_write;
    if (gnt[PORT_M1]) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_read  = m1_read;
      sel_write = m1_write;
    end
  end

  // Address is held when idle so the RAM's registered read port stays stable.
  always_comb begin
    mem_address    = any_gnt ? sel_addr : addr_hold_q;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wdata;
    mem_chipselect = any_gnt;
    mem_write      = any_gnt & sel_write;
    if (clearing) begin
      mem_address    = clr_addr;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end
  end

  assign mem_clken = 1'b1;

  // A write beats a simultaneous read on the same port, so no response.
  always_comb begin
    rvalid_d = any_gnt & sel_read & ~sel_write;
    rowner_d = gnt[PORT_M1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q    <= 1'b0;
      rowner_q    <= PORT_M0;
      addr_hold_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rowner_q <= rowner_d;
      if (any_gnt) begin
        addr_hold_q <= sel_addr;
      end
      if (m0_readdatavalid) begin
        rdata0_q <= mem_readdata;
      end
      if (m1_readdatavalid) begin
        rdata1_q <= mem_readdata;
      end
    end
  end

  assign m0_readdatavalid = rvalid_q & (rowner_q == PORT_M0);
  assign m1_readdatavalid = rvalid_q & (rowner_q == PORT_M1);
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : rdata0_q;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : rdata1_q;

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  logic              clr_pend_q;
  logic              clr_pend_d;

  // Grants are frozen as soon as a clear is requested; entry waits for the
  // in-flight read to drain.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    arb_en     = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (clear_req || clr_pend_q) begin
          arb_en = 1'b0;
          if (!rvalid_q) begin
            state_d    = ST_CLEAR;
            clr_pend_d = 1'b0;
            clr_addr_d = '0;
          end else begin
            clr_pend_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        arb_en     = 1'b0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (&clr_addr_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      clr_addr_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign clearing   = (state_q == ST_CLEAR);
  assign clear_busy = clearing;
  assign clr_addr   = clr_addr_q;
`else
  logic unused_clear_req;

  assign arb_en           = 1'b1;
  assign clearing         = 1'b0;
  assign clear_busy       = 1'b0;
  assign clr_addr         = '0;
  assign unused_clear_req = clear_req;
`endif

  a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write))
    else $warning("m0 read and write asserted together; write takes priority");
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write))
    else $warning("m1 read and write asserted together; write takes priority");

endmodule
`default_nettype wire
